// File: rtl/ctrl_upstream_arbiter_pkg.sv
// rtl/ctrl_upstream_arbiter_pkg.sv - shared control-message field positions and header codes
package ctrl_upstream_arbiter_pkg;

  localparam int MSG_HEADER_MSB = 63;
  localparam int MSG_HEADER_LSB = 56;
  localparam int MSG_DEST_MSB   = 55;
  localparam int MSG_DEST_LSB   = 48;

  localparam logic [7:0] HEADER_CMD    = 8'h01;
  localparam logic [7:0] HEADER_RESULT = 8'h02;
  localparam logic [7:0] HEADER_STATUS = 8'h03;

  // Index width for an n-entry select; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_upstream_arbiter_rr.sv
// rtl/ctrl_upstream_arbiter_rr.sv - combinational round-robin pick over N requests
// Search starts at ptr and wraps; first set request wins.
module rr_arbiter_n
  import ctrl_upstream_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    jj          = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!grant_valid && req[jj]) begin
        grant_valid = 1'b1;
        grant[jj]   = 1'b1;
        grant_idx   = jj;
      end
    end
  end

endmodule

// File: rtl/ctrl_upstream_arbiter.sv
// rtl/ctrl_upstream_arbiter.sv - merges child control streams into the root upstream port
// One hold slot per child feeds a single output register through a round-robin pick.
module ctrl_upstream_arbiter
  import ctrl_upstream_arbiter_pkg::*;
#(
  parameter int NUM_CHILDREN    = 4,
  parameter int CTRL_FIFO_WIDTH = 64,
  parameter int STAMP_SOURCE    = 1,
  localparam int IW = idx_width(NUM_CHILDREN)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] data_from_children,
  input  logic [NUM_CHILDREN-1:0]               valid_from_children,
  output logic [NUM_CHILDREN-1:0]               ready_from_children,
  output logic [CTRL_FIFO_WIDTH-1:0]            data_to_root,
  output logic                                  valid_to_root,
  input  logic                                  ready_to_root,
  output logic [IW-1:0]                         grant_id,
  output logic                                  router_busy
);

  localparam int N = NUM_CHILDREN;
  localparam int W = CTRL_FIFO_WIDTH;

  logic [N-1:0]  hold_valid_q, hold_valid_d;
  logic [W-1:0]  hold_data_q [N];
  logic [W-1:0]  hold_data_d [N];
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  win_onehot;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic          load_en;
  logic [W-1:0]  stamped;

  rr_arbiter_n #(.N(N)) u_rr (
    .req         (hold_valid_q),
    .ptr         (rr_ptr_q),
    .grant       (win_onehot),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    load_en      = !out_valid_q || ready_to_root;
    stamped      = hold_data_q[win_idx];
    if (STAMP_SOURCE != 0) stamped[MSG_DEST_MSB:MSG_DEST_LSB] = 8'(win_idx);

    // A full slot never captures, so the winner's clear cannot collide with a capture.
    for (int i = 0; i < N; i++) begin
      if (valid_from_children[i] && !hold_valid_q[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = data_from_children[i*W +: W];
      end
    end

    if (load_en) begin
      if (win_valid) begin
        out_data_d   = stamped;
        out_valid_d  = 1'b1;
        grant_d      = win_idx;
        hold_valid_d = hold_valid_d & ~win_onehot;
        rr_ptr_d     = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    busy_d = (|hold_valid_d) || out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
    end
  end

  assign ready_from_children = ~hold_valid_q;
  assign data_to_root        = out_data_q;
  assign valid_to_root       = out_valid_q;
  assign grant_id            = grant_q;
  assign router_busy         = busy_q;

endmodule

// File: tb/tb_ctrl_upstream_arbiter.sv
// tb/tb_ctrl_upstream_arbiter.sv - randomized and directed bench for ctrl_upstream_arbiter
module tb_ctrl_upstream_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] data_from_children;
  logic [N-1:0]   c_valid = '0;
  logic [W-1:0]   c_data [N];
  logic           ready_to_root = 1'b0;

  logic [N-1:0]   ready_from_children, ns_ready;
  logic [W-1:0]   data_to_root, ns_data;
  logic           valid_to_root, ns_valid;
  logic [1:0]     grant_id, ns_grant;
  logic           router_busy, ns_busy;

  always #5 clk = ~clk;

  always_comb begin
    data_from_children = '0;
    for (int i = 0; i < N; i++) data_from_children[i*W +: W] = c_data[i];
  end

  ctrl_upstream_arbiter #(.NUM_CHILDREN(N), .CTRL_FIFO_WIDTH(W), .STAMP_SOURCE(1)) dut (
    .clk(clk), .reset(reset),
    .data_from_children(data_from_children), .valid_from_children(c_valid),
    .ready_from_children(ready_from_children),
    .data_to_root(data_to_root), .valid_to_root(valid_to_root), .ready_to_root(ready_to_root),
    .grant_id(grant_id), .router_busy(router_busy)
  );

  ctrl_upstream_arbiter #(.NUM_CHILDREN(N), .CTRL_FIFO_WIDTH(W), .STAMP_SOURCE(0)) dut_ns (
    .clk(clk), .reset(reset),
    .data_from_children(data_from_children), .valid_from_children(c_valid),
    .ready_from_children(ns_ready),
    .data_to_root(ns_data), .valid_to_root(ns_valid), .ready_to_root(ready_to_root),
    .grant_id(ns_grant), .router_busy(ns_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference: each child owns one slot; the root sees one message at a time.
  bit           m_hold [N];
  logic [W-1:0] m_hdata [N];
  bit           m_ov;
  logic [W-1:0] m_out_raw, m_out_st;
  int           m_grant, m_ptr;
  bit           hs [N];
  logic [W-1:0] sb_q [N][$];
  int           rx_grant [$];

  bit           obs_valid;
  logic [W-1:0] obs_data, obs_data_ns;
  int           obs_grant;

  function automatic logic [W-1:0] stamp(input logic [W-1:0] d, input int g);
    logic [W-1:0] r;
    r = d;
    r[55:48] = 8'(g);
    return r;
  endfunction

  task automatic model_update();
    int win;
    logic [W-1:0] raw;
    for (int i = 0; i < N; i++) hs[i] = 0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_hold[i] = 0; sb_q[i].delete(); end
      m_ov = 0; m_out_raw = '0; m_out_st = '0; m_grant = 0; m_ptr = 0;
      return;
    end
    if (obs_valid && ready_to_root) begin
      rx_grant.push_back(obs_grant);
      check_eq("sb_avail", 64'(sb_q[obs_grant].size() > 0), 64'd1);
      if (sb_q[obs_grant].size() > 0) begin
        raw = sb_q[obs_grant].pop_front();
        check_eq("sb_data", obs_data, stamp(raw, obs_grant));
        check_eq("sb_data_ns", obs_data_ns, raw);
      end
    end
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && m_hold[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      if (c_valid[i] && !m_hold[i]) begin
        hs[i] = 1; m_hold[i] = 1; m_hdata[i] = c_data[i];
        sb_q[i].push_back(c_data[i]);
      end
    end
    if (!m_ov || ready_to_root) begin
      if (win >= 0) begin
        m_out_raw = m_hdata[win]; m_out_st = stamp(m_hdata[win], win);
        m_ov = 1; m_grant = win; m_hold[win] = 0; m_ptr = (win + 1) % N;
      end else m_ov = 0;
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_ready;
    bit any;
    any = m_ov;
    for (int i = 0; i < N; i++) begin exp_ready[i] = !m_hold[i]; any |= m_hold[i]; end
    check_eq("valid", 64'(valid_to_root), 64'(m_ov));
    check_eq("grant", 64'(grant_id), 64'(m_grant));
    check_eq("data", data_to_root, m_out_st);
    check_eq("ready", 64'(ready_from_children), 64'(exp_ready));
    check_eq("busy", 64'(router_busy), 64'(any));
    check_eq("data_ns", ns_data, m_out_raw);
    check_eq("ns_ctrl", 64'({ns_valid, ns_grant, ns_busy, ns_ready}),
             64'({m_ov, 2'(m_grant), any, exp_ready}));
    obs_valid = valid_to_root; obs_data = data_to_root;
    obs_data_ns = ns_data; obs_grant = int'(grant_id);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    for (int i = 0; i < N; i++) if (hs[i]) c_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; c_valid = '0;
    step();
    reset = 1'b0;
  endtask

  logic [W-1:0] d0;
  logic [1:0]   g0;
  int           base, cyc;

  initial begin
    for (int i = 0; i < N; i++) c_data[i] = '0;
    obs_valid = 0; obs_data = '0; obs_data_ns = '0; obs_grant = 0;
    @(negedge clk);
    do_reset();
    check_eq("rst_valid", 64'(valid_to_root), 64'd0);
    check_eq("rst_data", data_to_root, 64'd0);
    check_eq("rst_grant", 64'(grant_id), 64'd0);
    check_eq("rst_busy", 64'(router_busy), 64'd0);
    check_eq("rst_ready", 64'(ready_from_children), 64'hF);

    // single message, 2-cycle latency, stamped dest 0
    ready_to_root = 1'b1;
    c_valid[0] = 1'b1; c_data[0] = 64'h0000_0600_0000_0012;
    step();
    check_eq("t1_busy_e0", 64'(router_busy), 64'd1);
    check_eq("t1_valid_e0", 64'(valid_to_root), 64'd0);
    step();
    check_eq("t1_valid_e1", 64'(valid_to_root), 64'd1);
    check_eq("t1_data", data_to_root, 64'h0000_0600_0000_0012);
    check_eq("t1_grant", 64'(grant_id), 64'd0);
    step();
    check_eq("t1_busy_end", 64'(router_busy), 64'd0);

    // all four at once
    do_reset(); rx_grant.delete();
    for (int i = 0; i < N; i++) begin c_valid[i] = 1'b1; c_data[i] = 64'(i + 1); end
    cyc = 0;
    while (rx_grant.size() < 4 && cyc < 20) begin step(); cyc++; end
    check_eq("t2_count", 64'(rx_grant.size()), 64'd4);
    check_eq("t2_busy_drop", 64'(router_busy), 64'd0);
    for (int k = 0; k < rx_grant.size() && k < 4; k++) check_eq("t2_order", 64'(rx_grant[k]), 64'(k));

    // children 1 and 3 continuous, root ready toggling
    do_reset(); rx_grant.delete(); cyc = 0;
    while (rx_grant.size() < 200 && cyc < 3000) begin
      foreach (c_valid[i]) if ((i == 1 || i == 3) && !c_valid[i]) begin
        c_valid[i] = 1'b1; c_data[i] = {$urandom, $urandom};
      end
      ready_to_root = ~ready_to_root;
      step(); cyc++;
    end
    check_eq("t3_count", 64'(rx_grant.size() >= 200), 64'd1);
    for (int k = 0; k < rx_grant.size(); k++)
      check_eq("t3_alt", 64'(rx_grant[k]), (k % 2 == 0) ? 64'd1 : 64'd3);
    c_valid = '0; ready_to_root = 1'b1;
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < N; i++) check_eq("t3_drained", 64'(sb_q[i].size()), 64'd0);

    // root stalled with every child pending
    do_reset(); rx_grant.delete(); ready_to_root = 1'b0;
    for (int k = 0; k < 13; k++) begin
      foreach (c_valid[i]) if (!c_valid[i]) begin c_valid[i] = 1'b1; c_data[i] = {$urandom, $urandom}; end
      step();
      if (k == 2) begin d0 = data_to_root; g0 = grant_id; end
      if (k > 2) begin
        check_eq("t4_data_stable", data_to_root, d0);
        check_eq("t4_grant_stable", 64'(grant_id), 64'(g0));
        check_eq("t4_ready_zero", 64'(ready_from_children), 64'd0);
      end
    end
    c_valid = '0; ready_to_root = 1'b1; cyc = 0;
    while (rx_grant.size() < 5 && cyc < 20) begin step(); cyc++; end
    check_eq("t4_count", 64'(rx_grant.size()), 64'd5);
    for (int k = 0; k < rx_grant.size() && k < 5; k++)
      check_eq("t4_resume", 64'(rx_grant[k]), 64'(k % 4));

    // reset while busy
    do_reset(); ready_to_root = 1'b0;
    for (int i = 0; i < N; i++) begin c_valid[i] = 1'b1; c_data[i] = 64'(i + 8'h40); end
    step(); step();
    check_eq("t5_pre_valid", 64'(valid_to_root), 64'd1);
    check_eq("t5_pre_ready", 64'(ready_from_children), 64'h1);
    do_reset();
    check_eq("t5_valid", 64'(valid_to_root), 64'd0);
    check_eq("t5_busy", 64'(router_busy), 64'd0);
    check_eq("t5_ready", 64'(ready_from_children), 64'hF);

    // dest byte kept without stamping, replaced with stamping
    ready_to_root = 1'b1;
    c_valid[2] = 1'b1; c_data[2] = 64'h00AB_0000_0000_0005;
    step(); step();
    check_eq("t6_grant", 64'(ns_grant), 64'd2);
    check_eq("t6_ns_data", ns_data, 64'h00AB_0000_0000_0005);
    check_eq("t6_st_data", data_to_root, 64'h0002_0000_0000_0005);
    step();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      foreach (c_valid[i]) if (!c_valid[i] && $urandom_range(0, 1) == 1) begin
        c_valid[i] = 1'b1; c_data[i] = {$urandom, $urandom};
      end
      ready_to_root = ($urandom_range(0, 3) != 0);
      step();
    end
    c_valid = '0; ready_to_root = 1'b1;
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < N; i++) check_eq("rand_drained", 64'(sb_q[i].size()), 64'd0);
    check_eq("rand_idle", 64'(router_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
